// File: rtl/conv2d_stream_if.sv
// conv2d_stream_if: pixel-in / result-out stream bundle for conv2d_stream.
//   in_valid/in_ready/in_data            raster-order signed pixel stream
//   out_valid/out_ready/out_data/out_last signed result stream, last = final result of frame
// Modports: master = pixel source / result sink side, slave = convolution engine.
interface conv2d_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OUT_W  = 8
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming 3x3 signed convolution over an IMG_W x IMG_H frame.
// Two line buffers plus a 3x2 window register form each window; results come out
// of a 3-stage pipeline (products, sum, round/shift/saturate) with valid/ready
// backpressure. Only fully-covered (unpadded) windows produce results.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   coef_we/coef_addr/coef_data kernel write (IDLE only, index row*3+col, 0..8)
//   start                      begin a frame (IDLE only)
//   bus (slave)                pixel input stream and result output stream
//   busy, done, sat_flag       frame in progress, end-of-frame pulse, sticky saturation
// Build option: define CONV_RELU_EN to clamp negative results to zero after saturation.
module conv2d_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     start,
    conv2d_stream_if.slave           bus,
    output logic                     busy,
    output logic                     done,
    output logic                     sat_flag
);
    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned PW  = DATA_W + COEF_W;
    localparam int unsigned SW  = PW + 4;
    localparam int unsigned XW  = SW + 1;
    localparam int unsigned RSH = (FRAC_W > 0) ? FRAC_W - 1 : 0;
    localparam logic signed [XW-1:0] RND  = (FRAC_W > 0) ? (XW'(1) << RSH) : XW'(0);
    localparam logic signed [XW-1:0] OMAX = (XW'(1) << (OUT_W - 1)) - XW'(1);
    localparam logic signed [XW-1:0] OMIN = ~OMAX;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;

    state_t                   state_q, state_d;
    logic signed [COEF_W-1:0] coef [9];
    logic signed [DATA_W-1:0] lb0 [IMG_W];     // previous row
    logic signed [DATA_W-1:0] lb1 [IMG_W];     // row before that
    logic signed [DATA_W-1:0] win [3][2];      // two older columns of the window
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic signed [PW-1:0]     p1 [9];
    logic                     v1, l1, v2, l2;
    logic signed [SW-1:0]     s2;

    logic                     stall, accept, win_ok, frame_end;
    logic signed [DATA_W-1:0] tap [9];
    logic signed [SW-1:0]     sum_c;
    logic signed [XW-1:0]     shr_c;
    logic                     sat_c;
    logic signed [OUT_W-1:0]  res_c;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = (state_q == ST_STREAM) && !stall;
    assign accept       = bus.in_valid && bus.in_ready;
    assign win_ok       = accept && (col >= CW'(2)) && (row >= RW'(2));
    assign frame_end    = accept && (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

    // Window taps: two registered columns plus the column completed by this pixel
    always_comb begin
        tap[0] = win[0][0]; tap[1] = win[0][1]; tap[2] = lb1[col];
        tap[3] = win[1][0]; tap[4] = win[1][1]; tap[5] = lb0[col];
        tap[6] = win[2][0]; tap[7] = win[2][1]; tap[8] = bus.in_data;
    end

    // Adder tree feeding stage 2
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < 9; k++) sum_c = sum_c + SW'(p1[k]);
    end

    // Round half toward +inf, arithmetic shift, saturate
    always_comb begin
        shr_c = (XW'(s2) + RND) >>> FRAC_W;
        sat_c = (shr_c > OMAX) || (shr_c < OMIN);
        if (shr_c > OMAX)      res_c = OMAX[OUT_W-1:0];
        else if (shr_c < OMIN) res_c = OMIN[OUT_W-1:0];
        else                   res_c = shr_c[OUT_W-1:0];
`ifdef CONV_RELU_EN
        if (res_c[OUT_W-1]) res_c = '0;
`endif
    end

    // Frame control next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_STREAM;
            ST_STREAM: if (frame_end) state_d = ST_DRAIN;
            ST_DRAIN:  if (bus.out_valid && bus.out_ready && bus.out_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register with registered status decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == ST_STREAM) || (state_d == ST_DRAIN);
            done    <= (state_d == ST_DONE);
        end
    end

    // Kernel store, line buffers, counters and pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 9; k++) begin
                coef[k] <= '0;
                p1[k]   <= '0;
            end
            for (int x = 0; x < int'(IMG_W); x++) begin
                lb0[x] <= '0;
                lb1[x] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= '0;
                win[r][1] <= '0;
            end
            col           <= '0;
            row           <= '0;
            v1            <= 1'b0;
            l1            <= 1'b0;
            v2            <= 1'b0;
            l2            <= 1'b0;
            s2            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            sat_flag      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE) begin
                if (coef_we && (coef_addr < 4'd9)) coef[coef_addr] <= coef_data;
                if (start) begin
                    col      <= '0;
                    row      <= '0;
                    sat_flag <= 1'b0;
                end
            end

            if (accept) begin
                lb1[col] <= lb0[col];
                lb0[col] <= bus.in_data;
                for (int r = 0; r < 3; r++) win[r][0] <= win[r][1];
                win[0][1] <= lb1[col];
                win[1][1] <= lb0[col];
                win[2][1] <= bus.in_data;
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            // Whole pipeline freezes while the sink holds off a valid result
            if (!stall) begin
                v1 <= win_ok;
                l1 <= frame_end;
                for (int k = 0; k < 9; k++) p1[k] <= PW'(tap[k]) * PW'(coef[k]);
                v2 <= v1;
                l2 <= l1;
                s2 <= sum_c;
                bus.out_valid <= v2;
                bus.out_last  <= l2;
                if (v2) begin
                    bus.out_data <= res_c;
                    if (sat_c) sat_flag <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv2d_stream.sv
// tb_conv2d_stream: scoreboard bench for conv2d_stream (8x8 frame, FRAC_W=4).
// Expected results are computed from the bench's own image/kernel when each
// window's last pixel is handed over, and popped at each result handshake.
module tb_conv2d_stream;
    localparam int W = 8;
    localparam int H = 8;
    localparam int NPIX = W * H;
    localparam int NOUT = (W - 2) * (H - 2);

    logic              clk = 1'b0;
    logic              reset;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic              start;
    logic              busy, done, sat_flag;

    conv2d_stream_if #(.DATA_W(8), .OUT_W(8)) bus ();

    conv2d_stream dut (
        .clk       (clk),
        .reset     (reset),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int img [NPIX];
    int cf [9];
    logic signed [7:0] exp_d [$];
    logic              exp_l [$];
    bit                exp_sat;

    // Reference: window with bottom-right pixel (r,c)
    function automatic void push_expect(input int r, input int c);
        int s;
        int v;
        s = 0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                s += cf[kr*3 + kc] * img[(r - 2 + kr)*W + (c - 2 + kc)];
        v = (s + 8) >>> 4;
        if (v > 127) begin v = 127; exp_sat = 1'b1; end
        else if (v < -128) begin v = -128; exp_sat = 1'b1; end
`ifdef CONV_RELU_EN
        if (v < 0) v = 0;
`endif
        exp_d.push_back(8'(v));
        exp_l.push_back((r == H - 1) && (c == W - 1));
    endfunction

    task automatic write_coefs();
        for (int k = 0; k < 9; k++) begin
            coef_we = 1'b1; coef_addr = 4'(k); coef_data = 8'(cf[k]);
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic set_coefs(input int center, input int others);
        for (int k = 0; k < 9; k++) cf[k] = others;
        cf[4] = center;
    endtask

    // One frame: start pulse, pixel feeder and result sink run concurrently
    task automatic run_frame(input bit rv, input bit rr, input bit poke, input int sw_idx, input string name);
        int got;
        int t_acc;
        int t_out;
        bit prev_stall;
        logic signed [7:0] prev_d;
        logic prev_l;
        got = 0; t_acc = -1; t_out = -1; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        exp_d.delete(); exp_l.delete(); exp_sat = 1'b0;
        start = 1'b1;
        if (sw_idx >= 0) begin
            coef_we = 1'b1; coef_addr = 4'(sw_idx); coef_data = 8'(cf[sw_idx]);
        end
        @(posedge clk); #1;
        start = 1'b0; coef_we = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
        fork
            begin : feed
                int i;
                int guard;
                i = 0; guard = 0;
                while (i < NPIX && guard < 4000) begin
                    bus.in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.in_data  = 8'(img[i]);
                    if (poke && i == 10) begin
                        start = 1'b1; coef_we = 1'b1; coef_addr = 4'd4; coef_data = 8'sd99;
                    end
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) begin
                        if (i / W >= 2 && i % W >= 2) push_expect(i / W, i % W);
                        if (i == 2*W + 2) t_acc = cyc;
                        i++;
                    end
                    @(posedge clk); #1;
                    start = 1'b0; coef_we = 1'b0;
                    guard++;
                end
                bus.in_valid = 1'b0;
                checks++;
                if (i != NPIX) begin errors++; $display("FAIL %s pixels_accepted got=%0d exp=%0d", name, i, NPIX); end
            end
            begin : sink
                int guard;
                logic signed [7:0] ed;
                logic el;
                guard = 0;
                while (got < NOUT && guard < 4000) begin
                    bus.out_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    if (prev_stall) begin
                        checks++;
                        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_d || bus.out_last !== prev_l) begin
                            errors++;
                            $display("FAIL %s stall_hold got=%b/%0d/%b exp=1/%0d/%b", name,
                                     bus.out_valid, bus.out_data, bus.out_last, prev_d, prev_l);
                        end
                    end
                    prev_stall = bus.out_valid && !bus.out_ready;
                    prev_d = bus.out_data;
                    prev_l = bus.out_last;
                    if (bus.out_valid && bus.out_ready) begin
                        if (got == 0) t_out = cyc;
                        checks++;
                        if (exp_d.size() == 0) begin
                            errors++;
                            $display("FAIL %s unexpected_result got=%0d exp=none", name, bus.out_data);
                        end else begin
                            ed = exp_d.pop_front();
                            el = exp_l.pop_front();
                            if (bus.out_data !== ed || bus.out_last !== el) begin
                                errors++;
                                $display("FAIL %s result[%0d] got=%0d last=%b exp=%0d last=%b", name, got,
                                         bus.out_data, bus.out_last, ed, el);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    guard++;
                end
                bus.out_ready = 1'b1;
            end
        join
        checks++;
        if (got != NOUT) begin errors++; $display("FAIL %s result_count got=%0d exp=%0d", name, got, NOUT); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s done_pulse got done=%b busy=%b exp done=1 busy=0", name, done, busy);
        end
        checks++;
        if (sat_flag !== exp_sat) begin errors++; $display("FAIL %s sat_flag got=%b exp=%b", name, sat_flag, exp_sat); end
        if (!rv && !rr) begin
            checks++;
            if (t_out - t_acc != 3) begin errors++; $display("FAIL %s latency got=%0d exp=3", name, t_out - t_acc); end
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL %s after_done got done=%b out_valid=%b exp 0/0", name, done, bus.out_valid);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done, sat_flag} !== 14'd0) begin
            errors++;
            $display("FAIL %s outputs got rdy=%b ov=%b od=%0d ol=%b busy=%b done=%b sat=%b exp all 0", name,
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, busy, done, sat_flag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        set_coefs(16, 0);
        for (int i = 0; i < NPIX; i++) img[i] = i;
        write_coefs();
        run_frame(1'b0, 1'b0, 1'b0, -1, "identity");
    endtask

    task automatic test_box();
        set_coefs(16, 16);
        write_coefs();
        for (int i = 0; i < NPIX; i++) img[i] = 127;
        run_frame(1'b0, 1'b0, 1'b0, -1, "box_127");
        for (int i = 0; i < NPIX; i++) img[i] = -128;
        run_frame(1'b0, 1'b0, 1'b0, -1, "box_m128");
        for (int i = 0; i < NPIX; i++) img[i] = 10;
        run_frame(1'b0, 1'b0, 1'b0, -1, "box_10");
    endtask

    task automatic test_rounding();
        set_coefs(8, 0);
        write_coefs();
        for (int i = 0; i < NPIX; i++) img[i] = ((i / W + i % W) % 2 == 0) ? 3 : -3;
        run_frame(1'b0, 1'b0, 1'b0, -1, "rounding");
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 9; k++) cf[k] = $urandom_range(0, 32) - 16;
        write_coefs();
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
        run_frame(1'b0, 1'b0, 1'b0, -1, "free_run");
        run_frame(1'b1, 1'b1, 1'b0, -1, "backpressure");
        run_frame(1'b0, 1'b1, 1'b0, -1, "sink_stall");
    endtask

    task automatic test_control();
        set_coefs(16, 0);
        cf[0] = -4;
        write_coefs();
        // out-of-range kernel index must be dropped
        coef_we = 1'b1; coef_addr = 4'd12; coef_data = 8'sd99;
        @(posedge clk); #1;
        coef_we = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
        run_frame(1'b0, 1'b1, 1'b1, -1, "ignored_ctrl");
        // coefficients retained; write coinciding with start takes effect
        cf[8] = 5;
        run_frame(1'b1, 1'b0, 1'b0, 8, "start_with_write");
    endtask

    task automatic test_reset_midframe();
        int n;
        int seen;
        set_coefs(16, 0);
        write_coefs();
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        n = 0;
        bus.out_ready = 1'b1;
        for (int g = 0; g < 200 && n < 30; g++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'(g);
            @(negedge clk);
            if (bus.in_ready) n++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("reset_midframe");
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        @(posedge clk); #1;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_no_partial got=%0d exp=0", seen); end
        // kernel was cleared by reset
        set_coefs(0, 0);
        for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
        run_frame(1'b0, 1'b0, 1'b0, -1, "coef_cleared");
        set_coefs(16, 0);
        write_coefs();
        run_frame(1'b0, 1'b0, 1'b0, -1, "after_reset");
    endtask

    task automatic test_relu();
        set_coefs(-16, 0);
        write_coefs();
        for (int i = 0; i < NPIX; i++) img[i] = 5;
        run_frame(1'b0, 1'b0, 1'b0, -1, "relu");
    endtask

    initial begin
        reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        test_reset();
        test_identity();
        test_box();
        test_rounding();
        test_backpressure();
        test_control();
        test_reset_midframe();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
- Parametrised streaming 3x3 2D convolution engine; next generation of the fixed 8x8 frame convolver.
- Accepts one raster-order pixel per handshake, holds two image rows in line buffers, and emits one "valid" (unpadded) result per window.
- Adds programmable signed kernel, fixed-point round/saturate, valid/ready backpressure and frame start/done control.
- Sits between the pixel source and the result sink in the 2D convolution processor datapath.

Parameters:
DATA_W, 8, signed input pixel width
COEF_W, 8, signed kernel coefficient width
OUT_W, 8, signed output width after shift/saturate
FRAC_W, 4, coefficient fraction bits; arithmetic right shift applied to the sum (0 allowed)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
coef_we  in  1  kernel write strobe; honoured only in IDLE
coef_addr  in  4  kernel index 0..8 = row*3+col; 9..15 ignored
coef_data  in  COEF_W  signed coefficient
start  in  1  begin a frame; honoured only in IDLE
in_valid  in  1  pixel valid
in_ready  out  1  engine can accept pixel
in_data  in  DATA_W  signed pixel, raster order
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
out_data  out  OUT_W  signed result
out_last  out  1  marks final result of frame
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end
sat_flag  out  1  sticky: any result saturated this frame; cleared on start

Behaviour:
- Reset: in_ready, out_valid, out_data, out_last, busy, done, sat_flag = 0; all 9 coefficients = 0; FSM -> IDLE; pipeline, counters, line buffers cleared. Reset mid-frame aborts; no partial output afterwards.
- FSM: IDLE -> (start) STREAM -> (last pixel IMG_W*IMG_H accepted) DRAIN -> (last result handshaken) DONE -> IDLE. DONE lasts one cycle, done=1 there. start outside IDLE ignored.
- Coefficient write in same cycle as start: write takes effect, start accepted.
- Pixel handshake in_valid&&in_ready. in_ready = 1 in STREAM when pipeline not stalled; 0 in IDLE/DRAIN/DONE.
- Stall = out_valid && !out_ready; freezes line buffers, window, all pipeline stages; out_data/out_last stable while out_valid && !out_ready.
- Column/row counters wrap at IMG_W-1/IMG_H-1. Window valid when accepted pixel has col>=2 and row>=2; (IMG_W-2)*(IMG_H-2) results per frame, raster order.
- Pipeline: S1 nine products (DATA_W+COEF_W signed), S2 sum (DATA_W+COEF_W+4 bits), S3 round/shift/saturate. Result for window whose bottom-right pixel is accepted in cycle t drives out_valid at t+3 absent stalls.
- Rounding: if FRAC_W>0 add 2^(FRAC_W-1) then arithmetic shift right FRAC_W (round half toward +inf). Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; saturation sets sat_flag.
- out_last on the result of window (IMG_H-1, IMG_W-1). done asserts cycle after its handshake; busy drops with done.
- Coefficients retained across frames.

Optional Feature:
- CONV_RELU_EN defined: after saturation, negative results forced to 0 (sat_flag unaffected by ReLU). Undefined: signed result passed unchanged.

Test Plan:
- Identity: coef[4]=16, others 0, FRAC_W=4; 8x8 pixel=r*8+c (wrap to signed) -> 36 outputs equal din[r+1][c+1], out_last on 36th, done pulse next cycle.
- Box sum: all coef=1, FRAC_W=0, constant pixel 10 -> every out_data=90; 127 pixels -> out 127, sat_flag=1; -128 pixels -> out -128.
- Rounding: coef[4]=1, FRAC_W=1, pixels 3 and -3 -> 2 and -1.
- Backpressure: out_ready random 50%, in_valid random -> sequence identical to free-running run, no drops/duplicates, out_data stable during stall.
- Control: start/coef_we during STREAM ignored; reset at pixel 30 -> all outputs 0 next cycle, new frame then correct.
- CONV_RELU_EN: coef[4]=-16, pixel 5 -> out 0 with macro, -5 without.
